ifid_stage_reg: RTL and testbench

- IF/ID pipeline register. It is the receiving end of the load-use stall handshake.
- Captures PC and instruction from the fetch stage and presents them to decode.
- Holds on `ifid_continue` (stall, asserted high) and inserts a NOP bubble on `ifid_flush` (branch/jump redirect).
- A one-entry skid buffer catches the synchronous-imem word that lands during a stall. It also drives the register-address fields back to the hazard detection unit.

---
 rtl/ifid_stage_reg.sv | 113 +++++++++++
 tb/tb_ifid_stage_reg.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ifid_stage_reg.sv
// IF/ID pipeline register with stall hold, flush bubble, a one-entry skid buffer
// for the synchronous-imem word that lands during a stall, and perf counters.
module ifid_stage_reg #(
    parameter int          ADDR_W   = 32,
    parameter int          INST_W   = 32,
    parameter logic [31:0] NOP_INST = 32'h00000013,
    parameter int          CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic [INST_W-1:0] if_inst,
    input  logic              if_valid,
    input  logic              ifid_continue,
    input  logic              ifid_flush,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
    output logic              id_valid,
    output logic [4:0]        ifid_reg1_raddr,
    output logic [4:0]        ifid_reg2_raddr,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic              skid_ovf,
    output logic              dbg_skid_full
);

    localparam logic [INST_W-1:0] NOP_W   = INST_W'(NOP_INST);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    logic [ADDR_W-1:0] r_id_pc;
    logic [INST_W-1:0] r_id_inst;
    logic              r_id_valid;
    logic [ADDR_W-1:0] r_skid_pc;
    logic [INST_W-1:0] r_skid_inst;
    logic              r_skid_full;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;
    logic              r_skid_ovf;

    logic [CNT_W-1:0]  w_stall_cnt_inc;
    logic [CNT_W-1:0]  w_flush_cnt_inc;
    logic [4:0]        w_rs1;
    logic [4:0]        w_rs2;

    // Saturating increments: counters hold at all-ones instead of wrapping.
    assign w_stall_cnt_inc = (r_stall_cnt == CNT_MAX) ? r_stall_cnt : r_stall_cnt + 1'b1;
    assign w_flush_cnt_inc = (r_flush_cnt == CNT_MAX) ? r_flush_cnt : r_flush_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_id_pc     <= '0;
            r_id_inst   <= NOP_W;
            r_id_valid  <= 1'b0;
            r_skid_pc   <= '0;
            r_skid_inst <= NOP_W;
            r_skid_full <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_skid_ovf  <= 1'b0;
        end else if (ifid_flush) begin
            r_id_pc     <= if_pc;
            r_id_inst   <= NOP_W;
            r_id_valid  <= 1'b0;
            r_skid_full <= 1'b0;
            r_flush_cnt <= w_flush_cnt_inc;
        end else if (ifid_continue) begin
            r_stall_cnt <= w_stall_cnt_inc;
            if (if_valid) begin
                if (!r_skid_full) begin
                    r_skid_pc   <= if_pc;
                    r_skid_inst <= if_inst;
                    r_skid_full <= 1'b1;
                end else begin
                    r_skid_ovf  <= 1'b1;
                end
            end
        end else if (r_skid_full) begin
            // Older skid word issues first; the arriving word takes its place.
            r_id_pc     <= r_skid_pc;
            r_id_inst   <= r_skid_inst;
            r_id_valid  <= 1'b1;
            if (if_valid) begin
                r_skid_pc   <= if_pc;
                r_skid_inst <= if_inst;
            end else begin
                r_skid_full <= 1'b0;
            end
        end else if (if_valid) begin
            r_id_pc     <= if_pc;
            r_id_inst   <= if_inst;
            r_id_valid  <= 1'b1;
        end else begin
            r_id_pc     <= if_pc;
            r_id_inst   <= NOP_W;
            r_id_valid  <= 1'b0;
        end
    end

    // A bubble reports x0/x0 so hazard detection never sees a false dependency.
    assign w_rs1 = r_id_valid ? r_id_inst[19:15] : 5'd0;
    assign w_rs2 = r_id_valid ? r_id_inst[24:20] : 5'd0;

    assign id_pc           = r_id_pc;
    assign id_inst         = r_id_inst;
    assign id_valid        = r_id_valid;
    assign ifid_reg1_raddr = w_rs1;
    assign ifid_reg2_raddr = w_rs2;
    assign stall_cnt       = r_stall_cnt;
    assign flush_cnt       = r_flush_cnt;
    assign skid_ovf        = r_skid_ovf;
    assign dbg_skid_full   = r_skid_full;

endmodule

// File: tb/tb_ifid_stage_reg.sv
// Self-checking bench for ifid_stage_reg: exp_q holds fetched words still owed to decode.
module tb_ifid_stage_reg;

    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [31:0] ADD = 32'h00208033;

    logic        clk;
    logic        rst;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        ifid_continue;
    logic        ifid_flush;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
    logic [4:0]  ifid_reg1_raddr;
    logic [4:0]  ifid_reg2_raddr;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
    logic        skid_ovf;
    logic        dbg_skid_full;

    ifid_stage_reg dut (
        .clk             (clk),
        .rst             (rst),
        .if_pc           (if_pc),
        .if_inst         (if_inst),
        .if_valid        (if_valid),
        .ifid_continue   (ifid_continue),
        .ifid_flush      (ifid_flush),
        .id_pc           (id_pc),
        .id_inst         (id_inst),
        .id_valid        (id_valid),
        .ifid_reg1_raddr (ifid_reg1_raddr),
        .ifid_reg2_raddr (ifid_reg2_raddr),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt),
        .skid_ovf        (skid_ovf),
        .dbg_skid_full   (dbg_skid_full)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state
    logic [63:0] exp_q[$];
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    logic        exp_valid;
    logic [15:0] exp_stall;
    logic [15:0] exp_flush;
    logic        exp_ovf;
    int          n_chk;
    int          n_pass;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Drive one cycle, update expectations from the inputs, then compare after the edge.
    task automatic step(input logic r, input logic v, input logic [31:0] pc,
                        input logic [31:0] inst, input logic cont, input logic fl,
                        input logic chk);
        logic [63:0] w;
        rst = r; if_valid = v; if_pc = pc; if_inst = inst;
        ifid_continue = cont; ifid_flush = fl;
        if (r) begin
            exp_q.delete();
            exp_pc = '0; exp_inst = NOP; exp_valid = 1'b0;
            exp_stall = '0; exp_flush = '0; exp_ovf = 1'b0;
        end else if (fl) begin
            exp_q.delete();
            exp_pc = pc; exp_inst = NOP; exp_valid = 1'b0;
            exp_flush = sat_inc(exp_flush);
        end else if (cont) begin
            exp_stall = sat_inc(exp_stall);
            if (v) begin
                if (exp_q.size() == 0) exp_q.push_back({pc, inst});
                else exp_ovf = 1'b1;
            end
        end else begin
            if (v) exp_q.push_back({pc, inst});
            if (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                exp_pc = w[63:32]; exp_inst = w[31:0]; exp_valid = 1'b1;
            end else begin
                exp_pc = pc; exp_inst = NOP; exp_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        if (chk) begin
            check_eq("id_pc", 64'(id_pc), 64'(exp_pc));
            check_eq("id_inst", 64'(id_inst), 64'(exp_inst));
            check_eq("id_valid", 64'(id_valid), 64'(exp_valid));
            check_eq("raddr1", 64'(ifid_reg1_raddr), exp_valid ? 64'(exp_inst[19:15]) : 64'd0);
            check_eq("raddr2", 64'(ifid_reg2_raddr), exp_valid ? 64'(exp_inst[24:20]) : 64'd0);
            check_eq("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
            check_eq("flush_cnt", 64'(flush_cnt), 64'(exp_flush));
            check_eq("skid_ovf", 64'(skid_ovf), 64'(exp_ovf));
            check_eq("skid_full", 64'(dbg_skid_full), 64'(exp_q.size()));
        end
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        rst = 1'b1; if_valid = 1'b0; if_pc = '0; if_inst = '0;
        ifid_continue = 1'b0; ifid_flush = 1'b0;
        exp_pc = '0; exp_inst = NOP; exp_valid = 1'b0;
        exp_stall = '0; exp_flush = '0; exp_ovf = 1'b0;

        // reset held two cycles, released with no fetch
        step(1, 0, 32'h0, 32'h0, 0, 0, 1);
        step(1, 1, 32'h40, ADD, 1, 1, 1);
        step(0, 0, 32'h0, 32'h0, 0, 0, 1);
        check_eq("rst_inst_nop", 64'(id_inst), 64'h13);

        // plain stream: one-cycle latency, rs1=1 rs2=2
        step(0, 1, 32'h00, ADD, 0, 0, 1);
        step(0, 1, 32'h04, ADD, 0, 0, 1);
        check_eq("stream_pc4", 64'(id_pc), 64'h4);
        step(0, 1, 32'h08, ADD, 0, 0, 1);
        check_eq("stream_rs1", 64'(ifid_reg1_raddr), 64'd1);
        check_eq("stream_rs2", 64'(ifid_reg2_raddr), 64'd2);
        step(0, 0, 32'h0, 32'h0, 0, 0, 1);

        // single stall while 0x04 is in ID and 0x08 arrives
        step(0, 1, 32'h04, 32'h00310093, 0, 0, 1);
        step(0, 1, 32'h08, 32'h00418113, 1, 0, 1);
        check_eq("stall_hold_pc", 64'(id_pc), 64'h4);
        step(0, 1, 32'h0C, 32'h00520193, 0, 0, 1);
        check_eq("skid_issue_pc", 64'(id_pc), 64'h8);
        step(0, 0, 32'h10, 32'h0, 0, 0, 1);
        check_eq("after_skid_pc", 64'(id_pc), 64'hC);
        check_eq("stall_cnt_one", 64'(stall_cnt), 64'd1);

        // stall + flush with the skid full
        step(0, 1, 32'h20, ADD, 0, 0, 1);
        step(0, 1, 32'h24, ADD, 1, 0, 1);
        step(0, 1, 32'h28, ADD, 1, 1, 1);
        check_eq("flush_cnt_one", 64'(flush_cnt), 64'd1);
        check_eq("flush_stall_same", 64'(stall_cnt), 64'd2);
        step(0, 0, 32'h0, 32'h0, 0, 0, 1);

        // two-cycle stall with fetch on both: second word dropped, sticky overflow
        step(0, 1, 32'h30, ADD, 0, 0, 1);
        step(0, 1, 32'h34, ADD, 1, 0, 1);
        step(0, 1, 32'h38, ADD, 1, 0, 1);
        for (int i = 0; i < 10; i++) step(0, 1'(i % 2), 32'h40 + 32'(4 * i), ADD, 0, 0, 1);
        check_eq("ovf_sticky", 64'(skid_ovf), 64'd1);
        step(1, 0, 32'h0, 32'h0, 0, 0, 1);
        check_eq("ovf_cleared", 64'(skid_ovf), 64'd0);

        // randomised traffic against the scoreboard
        for (int i = 0; i < 300; i++) begin
            step(0, 1'($urandom_range(0, 3) != 0), 32'($urandom_range(0, 1023)) << 2,
                 32'($urandom()), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 15) == 0), 1);
        end
        step(1, 0, 32'h0, 32'h0, 0, 0, 1);

        // long stall to saturate stall_cnt
        for (int i = 0; i < 65540; i++) step(0, 0, 32'h0, 32'h0, 1, 0, 0);
        step(0, 0, 32'h0, 32'h0, 1, 0, 1);
        check_eq("stall_sat", 64'(stall_cnt), 64'hFFFF);
        step(0, 1, 32'h80, ADD, 0, 0, 1);
        check_eq("stall_sat_hold", 64'(stall_cnt), 64'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
